// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: groups the bus-side push port, the transmitter-side
// pull port and the status outputs of uart_tx_fifo.
//   master : driver of the FIFO (bus/CPU + transmitter side)
//   slave  : the FIFO itself
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic [WIDTH-1:0] write_data_i;
  logic             write_enable_i;
  logic             full_o;
  logic             empty_o;
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic             read_enable_i;
  logic [WIDTH-1:0] read_data_o;
  logic             read_valid_o;

  modport master (
    output flush_i, write_data_i, write_enable_i, read_enable_i,
    input  full_o, empty_o, count_o, overflow_o, read_data_o, read_valid_o
  );

  modport slave (
    input  flush_i, write_data_i, write_enable_i, read_enable_i,
    output full_o, empty_o, count_o, overflow_o, read_data_o, read_valid_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter.
//   clk_i      : system clock
//   reset_n_i  : synchronous active-low reset
//   bus        : uart_tx_fifo_if.slave
//     flush_i / write_data_i / write_enable_i : bus-side enqueue + flush
//     read_enable_i                           : transmitter idle (level)
//     read_data_o / read_valid_o              : popped byte + 1-cycle pulse
//     full_o / empty_o / count_o / overflow_o : status (overflow is sticky)
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  uart_tx_fifo_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full, empty, push, pop;

  // Status decodes from the registered count, so it is start-of-cycle.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.write_enable_i && !full;
  // Transmitter keeps read_enable high during its valid cycle; the
  // !rvalid_q term stops a second pop there that would lose a byte.
  assign pop   = bus.read_enable_i && !empty && !rvalid_q;

  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    if (bus.flush_i) begin
      // Flush wins over push/pop; last read data is intentionally kept.
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (bus.write_enable_i && full) ovf_d = 1'b1;
      if (push) wr_d = wr_q + 1'b1;
      if (pop) begin
        rd_d     = rd_q + 1'b1;
        rdata_d  = mem_q[rd_q];
        rvalid_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable via the pointers.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !bus.flush_i && push) mem_q[wr_q] <= bus.write_data_i;
  end

  assign bus.full_o       = full;
  assign bus.empty_o      = empty;
  assign bus.count_o      = count_q;
  assign bus.overflow_o   = ovf_q;
  assign bus.read_valid_o = rvalid_q;
  assign bus.read_data_o  = rdata_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: a queue of bytes plus output registers.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_rv  = 1'b0;
  logic [WIDTH-1:0] m_rd  = '0;
  int               m_wr_tot = 0, m_rd_tot = 0;

  always @(posedge clk) begin
    bit full_s, empty_s, do_pop, do_push;
    if (!rst_n) begin
      m_q.delete(); m_ovf = 0; m_rv = 0; m_rd = '0; m_wr_tot = 0; m_rd_tot = 0;
    end else if (bus.flush_i) begin
      m_q.delete(); m_ovf = 0; m_rv = 0; m_wr_tot = 0; m_rd_tot = 0;
    end else begin
      full_s  = (m_q.size() == DEPTH);
      empty_s = (m_q.size() == 0);
      do_pop  = bus.read_enable_i && !empty_s && !m_rv;
      do_push = bus.write_enable_i && !full_s;
      if (bus.write_enable_i && full_s) m_ovf = 1;
      m_rv = do_pop;
      if (do_pop) begin m_rd = m_q.pop_front(); m_rd_tot++; end
      if (do_push) begin m_q.push_back(bus.write_data_i); m_wr_tot++; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",    32'(bus.count_o),      32'(m_q.size()));
      chk("full",     32'(bus.full_o),       32'(m_q.size() == DEPTH));
      chk("empty",    32'(bus.empty_o),      32'(m_q.size() == 0));
      chk("overflow", 32'(bus.overflow_o),   32'(m_ovf));
      chk("rvalid",   32'(bus.read_valid_o), 32'(m_rv));
      chk("rdata",    32'(bus.read_data_o),  32'(m_rd));
      chk("wr_minus_rd", 32'(bus.count_o), 32'((m_wr_tot - m_rd_tot) % (2*DEPTH)));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.flush_i = 0; bus.write_enable_i = 0; bus.read_enable_i = 0; bus.write_data_i = '0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; tick(); tick(); rst_n = 1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.read_valid_o && n < budget) begin tick(); n++; end
    if (!bus.read_valid_o) begin n_tests++; n_fail++; $display("FAIL %s: no read_valid within %0d cycles", name, budget); end
  endtask

  initial begin
    int pulses, last_pulse;
    idle();
    do_reset();
    chk_en = 1;
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_rdata", 32'(bus.read_data_o), 0);

    // 1. single byte latency
    bus.write_enable_i = 1; bus.write_data_i = 8'h41; bus.read_enable_i = 1;
    tick();
    chk("t1_empty_c1", 32'(bus.empty_o), 0);
    chk("t1_rv_c1", 32'(bus.read_valid_o), 0);
    bus.write_enable_i = 0;
    tick();
    chk("t1_rv_c2", 32'(bus.read_valid_o), 1);
    chk("t1_data_c2", 32'(bus.read_data_o), 32'h41);
    chk("t1_empty_c2", 32'(bus.empty_o), 1);
    tick();
    chk("t1_rv_c3", 32'(bus.read_valid_o), 0);

    // 2. fill and overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.write_enable_i = 1; bus.write_data_i = 8'(i); tick();
    end
    chk("t2_full", 32'(bus.full_o), 1);
    chk("t2_count", 32'(bus.count_o), 16);
    chk("t2_ovf_pre", 32'(bus.overflow_o), 0);
    bus.write_data_i = 8'hAA; tick();
    bus.write_enable_i = 0;
    chk("t2_ovf", 32'(bus.overflow_o), 1);
    chk("t2_count_hold", 32'(bus.count_o), 16);

    // 3. drain with read_enable held: one pulse every second cycle
    bus.read_enable_i = 1;
    pulses = 0; last_pulse = -2;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.read_valid_o) begin
        chk("t3_data", 32'(bus.read_data_o), 32'(pulses));
        if (pulses > 0) chk("t3_spacing", 32'(c - last_pulse), 2);
        last_pulse = c; pulses++;
      end
    end
    chk("t3_pulses", 32'(pulses), 16);
    chk("t3_empty", 32'(bus.empty_o), 1);
    bus.read_enable_i = 0;

    // 4. steady state at 3 entries, 40 bytes through the wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.write_enable_i = 1; bus.write_data_i = 8'(8'h80 + i); tick();
    end
    bus.read_enable_i = 1;
    for (int i = 0; i < 80; i++) begin
      // push only in cycles where a pop also happens
      bus.write_enable_i = !m_rv; bus.write_data_i = 8'(i);
      tick();
      chk("t4_count", 32'(bus.count_o), 3);
    end
    idle();
    tick(); tick();

    // 5. flush beats push and pop
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.write_enable_i = 1; bus.write_data_i = 8'(i + 8'h10); tick();
    end
    bus.write_enable_i = 0; bus.read_enable_i = 1;
    for (int i = 0; i < 40 && bus.count_o != 5; i++) tick();
    chk("t5_count5", 32'(bus.count_o), 5);
    bus.read_enable_i = 0;
    tick(); tick();
    bus.read_enable_i = 1; bus.write_enable_i = 1; bus.flush_i = 1; bus.write_data_i = 8'h77;
    tick();
    idle();
    chk("t5_count", 32'(bus.count_o), 0);
    chk("t5_empty", 32'(bus.empty_o), 1);
    chk("t5_ovf", 32'(bus.overflow_o), 0);
    chk("t5_rv", 32'(bus.read_valid_o), 0);
    tick();

    // 6. reset mid-drain while read_valid is high
    for (int i = 0; i < 4; i++) begin
      bus.write_enable_i = 1; bus.write_data_i = 8'(8'hC0 + i); tick();
    end
    bus.write_enable_i = 0; bus.read_enable_i = 1;
    wait_valid("t6_drain", 10);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6_rv", 32'(bus.read_valid_o), 0);
    chk("t6_count", 32'(bus.count_o), 0);
    chk("t6_empty", 32'(bus.empty_o), 1);
    chk("t6_full", 32'(bus.full_o), 0);
    chk("t6_ovf", 32'(bus.overflow_o), 0);
    chk("t6_rdata", 32'(bus.read_data_o), 0);
    bus.read_enable_i = 0; bus.write_enable_i = 1; bus.write_data_i = 8'h5A; tick();
    bus.write_enable_i = 0; bus.read_enable_i = 1;
    wait_valid("t6_after", 10);
    chk("t6_first_data", 32'(bus.read_data_o), 32'h5A);
    idle(); tick();

    // Random traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      bus.write_enable_i = ($urandom_range(0, 99) < 55);
      bus.write_data_i   = 8'($urandom);
      bus.read_enable_i  = ($urandom_range(0, 99) < 45);
      bus.flush_i        = ($urandom_range(0, 199) == 0);
      rst_n              = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle(); rst_n = 1; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
